// File: rtl/adder_frame_acc_pkg.sv
// Shared types and defaults for the adder frame accumulator slice.
// Holds the FSM state encoding and the width helpers used by the interface and top.
package adder_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_FRAME_LEN = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Accumulator must hold FRAME_LEN*(2^WIDTH-1) without wrapping.
    function automatic int acc_width(input int width, input int frame_len);
        return width + $clog2(frame_len);
    endfunction

    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/adder_frame_acc_if.sv
// Sample-in / summary-out bus between an adder under observation and the frame accumulator.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid && ready;
// the source holds its payload stable while valid is high and ready is low.
interface adder_intf
    import adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
);

    localparam int ACC_WIDTH = acc_width(WIDTH, FRAME_LEN);
    localparam int CNT_WIDTH = cnt_width(FRAME_LEN);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     in_result;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic [CNT_WIDTH-1:0] out_ovf_cnt;
    logic [CNT_WIDTH-1:0] out_mism_cnt;

    modport master (
        output in_valid, in_a, in_b, in_result, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf_cnt, out_mism_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_result, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf_cnt, out_mism_cnt
    );

endinterface

// File: rtl/adder_frame_acc_check.sv
// Per-sample adder check: recomputes a+b at WIDTH+1 bits to derive carry-out
// and whether the reported result disagrees with the true WIDTH-bit sum.
module adder_sample_check #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_carry,
    output logic             o_mismatch
);

    logic [WIDTH:0] w_sum;

    assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry    = w_sum[WIDTH];
    assign o_mismatch = (w_sum[WIDTH-1:0] != i_result);

endmodule

// File: rtl/adder_frame_acc.sv
// Accumulates adder samples into frames of FRAME_LEN (or shorter on flush) and
// holds a summary of sum, count, carry-outs and result mismatches until consumed.
module adder_frame_acc
    import adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    adder_intf.slave   bus,
    output state_t     o_dbg_state
);

    localparam int ACC_WIDTH = acc_width(WIDTH, FRAME_LEN);
    localparam int CNT_WIDTH = cnt_width(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_ovf_cnt;
    logic [CNT_WIDTH-1:0] r_mism_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic                 w_carry;
    logic                 w_mismatch;
    logic                 w_accept;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_ovf_next;
    logic [CNT_WIDTH-1:0] w_mism_next;
    logic                 w_frame_full;
    logic                 w_flush_go;
    logic                 w_to_hold;

    adder_sample_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .i_a        (bus.in_a),
        .i_b        (bus.in_b),
        .i_result   (bus.in_result),
        .o_carry    (w_carry),
        .o_mismatch (w_mismatch)
    );

    // r_in_ready is only ever high in ACCUM, so it alone qualifies acceptance.
    assign w_accept = bus.in_valid && r_in_ready;

    always_comb begin
        w_acc_next  = r_acc;
        w_cnt_next  = r_cnt;
        w_ovf_next  = r_ovf_cnt;
        w_mism_next = r_mism_cnt;
        if (w_accept) begin
            w_acc_next  = r_acc + {{(ACC_WIDTH-WIDTH){1'b0}}, bus.in_result};
            w_cnt_next  = r_cnt + CNT_WIDTH'(1);
            w_ovf_next  = r_ovf_cnt + CNT_WIDTH'(w_carry);
            w_mism_next = r_mism_cnt + CNT_WIDTH'(w_mismatch);
        end
    end

    // A same-cycle accept counts toward the flush decision and is part of the frame.
    assign w_frame_full = w_accept && (w_cnt_next == FRAME_LEN_C);
    assign w_flush_go   = bus.flush && (w_cnt_next != '0);
    assign w_to_hold    = (r_state == ACCUM) && (w_frame_full || w_flush_go);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_cnt   <= '0;
            r_mism_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_acc      <= w_acc_next;
                    r_cnt      <= w_cnt_next;
                    r_ovf_cnt  <= w_ovf_next;
                    r_mism_cnt <= w_mism_next;
                    r_in_ready <= 1'b1;
                    if (w_to_hold) begin
                        r_state     <= HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Summary registers stay frozen until the consumer takes them.
                    if (bus.out_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf_cnt   <= '0;
                        r_mism_cnt  <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_acc;
    assign bus.out_count    = r_cnt;
    assign bus.out_ovf_cnt  = r_ovf_cnt;
    assign bus.out_mism_cnt = r_mism_cnt;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_adder_frame_acc.sv
// Directed bench for adder_frame_acc: table of full frames plus hand-written
// sequences for back-pressure, flush, ignored flush and mid-frame reset.
module tb_adder_frame_acc;
    import adder_pkg::*;

    typedef struct packed {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [3:0][7:0] r;
        logic [9:0]      sum;
        logic [2:0]      cnt;
        logic [2:0]      ovf;
        logic [2:0]      mism;
    } frame_t;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_checks;
    int     n_pass;
    logic [18:0] exp_q[$];
    frame_t vecs[3];

    adder_intf #(.WIDTH(8), .FRAME_LEN(4)) bus ();

    adder_frame_acc #(
        .WIDTH     (8),
        .FRAME_LEN (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // driver: present one sample (optionally with flush) and wait for its accept edge
    task automatic put_sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                              input logic fl);
        bit done;
        done          = 1'b0;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_result = r;
        bus.in_valid  = 1'b1;
        bus.flush     = fl;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: sample a=%0d never accepted", a);
        end
    endtask

    task automatic push_exp(input logic [9:0] sum, input logic [2:0] cnt,
                            input logic [2:0] ovf, input logic [2:0] mism);
        exp_q.push_back({sum, cnt, ovf, mism});
    endtask

    // scoreboard: wait for a summary, compare against the queue head, consume it
    task automatic drain(input string tag);
        bit          seen;
        logic [18:0] e;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL %s_valid_timeout: got out_valid=0 expected 1", tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_queue: got empty expected queue, required an entry", tag);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_sum"},   32'(bus.out_sum),      32'(e[18:9]));
        check({tag, "_count"}, 32'(bus.out_count),    32'(e[8:6]));
        check({tag, "_ovf"},   32'(bus.out_ovf_cnt),  32'(e[5:3]));
        check({tag, "_mism"},  32'(bus.out_mism_cnt), 32'(e[2:0]));
        check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_cleared"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"},    32'(bus.in_ready),  32'd1);
        check({tag, "_count_cleared"}, 32'(bus.out_count), 32'd0);
        check({tag, "_sum_cleared"},   32'(bus.out_sum),   32'd0);
    endtask

    task automatic send_frame(input frame_t f, input string tag);
        push_exp(f.sum, f.cnt, f.ovf, f.mism);
        for (int j = 0; j < 4; j++) begin
            put_sample(f.a[j], f.b[j], f.r[j], 1'b0);
            if (j < 3) check({tag, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0].a = {8'd100, 8'd10, 8'd4, 8'd1};
        vecs[0].b = {8'd100, 8'd20, 8'd5, 8'd2};
        vecs[0].r = {8'd200, 8'd30, 8'd9, 8'd3};
        vecs[0].sum = 10'd242; vecs[0].cnt = 3'd4; vecs[0].ovf = 3'd0; vecs[0].mism = 3'd0;
        vecs[1].a = {8'd0, 8'd128, 8'd128, 8'd255};
        vecs[1].b = {8'd0, 8'd127, 8'd128, 8'd255};
        vecs[1].r = {8'd0, 8'd255, 8'd0, 8'd254};
        vecs[1].sum = 10'd509; vecs[1].cnt = 3'd4; vecs[1].ovf = 3'd2; vecs[1].mism = 3'd0;
        vecs[2].a = {8'd0, 8'd2, 8'd1, 8'd3};
        vecs[2].b = {8'd1, 8'd2, 8'd1, 8'd4};
        vecs[2].r = {8'd1, 8'd4, 8'd2, 8'd8};
        vecs[2].sum = 10'd15; vecs[2].cnt = 3'd4; vecs[2].ovf = 3'd0; vecs[2].mism = 3'd1;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_result = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count",     32'(bus.out_count), 32'd0);
        check("rst_sum",       32'(bus.out_sum),   32'd0);
        check("rst_state",     32'(dbg_state),     32'(ACCUM));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_ready_after_edge", 32'(bus.in_ready), 32'd1);

        // table-driven full frames
        for (int k = 0; k < 3; k++) begin
            send_frame(vecs[k], $sformatf("frame%0d", k));
            check($sformatf("frame%0d_state", k), 32'(dbg_state), 32'(HOLD));
            drain($sformatf("frame%0d", k));
        end

        // back-pressure: summary held 5 cycles, new sample and flush ignored meanwhile
        send_frame(vecs[0], "bp");
        bus.in_a = 8'd9; bus.in_b = 8'd9; bus.in_result = 8'd18;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_ready_low",  32'(bus.in_ready),  32'd0);
            check("bp_sum_stable", 32'(bus.out_sum),   32'd242);
            check("bp_cnt_stable", 32'(bus.out_count), 32'd4);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        drain("bp");

        // flush with empty frame does nothing
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("empty_flush_valid", 32'(bus.out_valid), 32'd0);
        check("empty_flush_state", 32'(dbg_state),     32'(ACCUM));

        // flush together with the accepting sample
        push_exp(10'd24, 3'd2, 3'd0, 3'd0);
        put_sample(8'd5, 8'd5, 8'd10, 1'b0);
        put_sample(8'd7, 8'd7, 8'd14, 1'b1);
        drain("flush_same");

        // flush on its own after one sample
        push_exp(10'd2, 3'd1, 3'd0, 3'd0);
        put_sample(8'd1, 8'd1, 8'd2, 1'b0);
        check("one_sample_no_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        drain("flush_alone");

        // reset mid-frame discards the partial frame
        put_sample(8'd50, 8'd50, 8'd100, 1'b0);
        put_sample(8'd60, 8'd60, 8'd120, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.in_ready),  32'd0);
        check("midrst_count", 32'(bus.out_count), 32'd0);
        check("midrst_sum",   32'(bus.out_sum),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_still_no_valid", 32'(bus.out_valid), 32'd0);
        send_frame(vecs[0], "after_rst");
        drain("after_rst");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
